// File: rtl/logs_voice.sv
// Single-voice square-wave note player: accepts (period, length) notes and emits a registered tone.
// Optional build macro LOGS_VOICE_GAP_EN inserts a silent TICK_DIV-clock gap after every note.
module logs_voice #(
  parameter int PERIOD_W = 12,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_len,
  output logic                busy,
  output logic                audio_out
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef LOGS_VOICE_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] phase_cnt;
  logic [DUR_W-1:0]    rem_len;
  logic [TICK_W-1:0]   tick_cnt;
  logic                accept;
  logic                tick_wrap;
  logic                last_play;
  logic                toggle;

  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    accept    = note_valid && note_ready;
    tick_wrap = (tick_cnt == TICK_LAST);
    // rem_len counts whole ticks still to play, so the final clock is the wrap with one tick left
    last_play = (state == PLAY) && tick_wrap && (rem_len == DUR_W'(1));
    toggle    = (state == PLAY) && (period_q != '0) &&
                (phase_cnt == period_q - PERIOD_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (note_len != '0)) state_nxt = PLAY;
      PLAY: begin
        if (last_play) begin
`ifdef LOGS_VOICE_GAP_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef LOGS_VOICE_GAP_EN
      GAP: if (tick_wrap) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period_q  <= '0;
      phase_cnt <= '0;
      rem_len   <= '0;
      tick_cnt  <= '0;
      audio_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept && (note_len != '0)) begin
            period_q  <= note_period;
            rem_len   <= note_len;
            phase_cnt <= '0;
            tick_cnt  <= '0;
            audio_out <= 1'b0;
          end
        end
        PLAY: begin
          tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
          if (tick_wrap) rem_len <= rem_len - DUR_W'(1);
          if (toggle) phase_cnt <= '0;
          else if (period_q != '0) phase_cnt <= phase_cnt + PERIOD_W'(1);
          if (last_play) audio_out <= 1'b0;
          else if (toggle) audio_out <= ~audio_out;
        end
`ifdef LOGS_VOICE_GAP_EN
        // tick_cnt has just wrapped to 0 on the last PLAY clock, so it times the gap directly
        GAP: tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logs_voice.sv
// Scoreboard bench for logs_voice: stimulus queues per-cycle {ready,busy,audio} expectations,
// a negedge monitor pops and compares them.
module tb_logs_voice;

  logic       clk = 1'b0;
  logic       reset;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_period;
  logic [3:0] note_len;
  logic       busy;
  logic       audio_out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

`ifdef LOGS_VOICE_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];

  logs_voice #(.PERIOD_W(4), .DUR_W(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_period(note_period),
    .note_len   (note_len),
    .busy       (busy),
    .audio_out  (audio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d expectation missed (now cyc=%0d)", e.name, e.cyc, cyc);
      end else if ({note_ready, busy, audio_out} !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d ready/busy/audio got %b expected %b",
                 e.name, cyc, {note_ready, busy, audio_out}, e.exp);
      end
    end
  end

  function automatic void push(input int c, input logic [2:0] e, input string nm);
    exp_t x;
    x.cyc = c; x.exp = e; x.name = nm;
    q.push_back(x);
  endfunction

  // PLAY cycles k=1..4*len carry audio pat[k-1]; optional gap; then one idle cycle.
  function automatic int push_note(input int c, input int len, input logic [63:0] pat,
                                   input string nm);
    int n = 4 * len;
    for (int k = 1; k <= n; k++) push(c + k, {2'b01, pat[k-1]}, nm);
    for (int k = 1; k <= G; k++) push(c + n + k, 3'b010, {nm, "_gap"});
    push(c + n + G + 1, 3'b100, {nm, "_idle"});
    return c + n + G + 1;
  endfunction

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain timeout: %0d expectations pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic note(input logic [3:0] p, input logic [3:0] l, input logic [63:0] pat,
                      input string nm);
    int c, idle_c;
    @(negedge clk);
    note_valid = 1'b1; note_period = p; note_len = l;
    c = cyc;
    idle_c = push_note(c, int'(l), pat, nm);
    @(posedge clk); #1 note_valid = 1'b0;
    drain();
  endtask

  initial begin
    int c, i_c;
    reset = 1'b1; note_valid = 1'b0; note_period = '0; note_len = '0;
    @(negedge clk); @(negedge clk);
    push(cyc + 1, 3'b100, "reset_state");
    @(negedge clk);
    reset = 1'b0;
    push(cyc + 1, 3'b100, "post_reset_idle");
    drain();

    note(4'd3, 4'd2, 64'h38, "p3l2");
    note(4'd1, 4'd1, 64'hA, "p1l1");
    note(4'd0, 4'd3, 64'h0, "rest_l3");
    note(4'd2, 4'd2, 64'hCC, "p2l2");
    note(4'd15, 4'd1, 64'h0, "p15l1");
    note(4'd1, 4'd15, 64'h0AAA_AAAA_AAAA_AAAA, "p1l15_max");
`ifdef LOGS_VOICE_GAP_EN
    note(4'd2, 4'd1, 64'hC, "gap_p2l1");
`endif

    // zero-length note is discarded
    @(negedge clk);
    note_valid = 1'b1; note_period = 4'd3; note_len = 4'd0;
    c = cyc;
    push(c + 1, 3'b100, "len0_a");
    push(c + 2, 3'b100, "len0_b");
    @(posedge clk); #1 note_valid = 1'b0;
    drain();

    // valid held through PLAY: fields sampled only on the first IDLE cycle
    @(negedge clk);
    note_valid = 1'b1; note_period = 4'd1; note_len = 4'd1;
    c = cyc;
    i_c = push_note(c, 1, 64'hA, "held1");
    void'(push_note(i_c, 1, 64'hC, "held2"));
    @(posedge clk); #1 note_period = 4'd3; note_len = 4'd2;
    while (cyc < i_c - 1) @(negedge clk);
    note_period = 4'd2; note_len = 4'd1;
    while (cyc < i_c + 1) @(negedge clk);
    note_valid = 1'b0;
    drain();

    // reset on PLAY cycle 5 of period=2, len=3
    @(negedge clk);
    note_valid = 1'b1; note_period = 4'd2; note_len = 4'd3;
    c = cyc;
    for (int k = 1; k <= 5; k++) push(c + k, {2'b01, (k == 3 || k == 4) ? 1'b1 : 1'b0}, "abort_play");
    push(c + 6, 3'b100, "abort_idle");
    push(c + 7, 3'b100, "abort_idle2");
    @(posedge clk); #1 note_valid = 1'b0;
    while (cyc < c + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain();

    // a fresh note after the abort plays normally
    note(4'd1, 4'd1, 64'hA, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logs_voice.md
LOGS_VOICE -- requirements
Module: logs_voice

Interface
REQ-001 SHALL have parameter PERIOD_W, default 12, width of the half-period field in clocks.
REQ-002 SHALL have parameter DUR_W, default 8, width of the note-length field in ticks.
REQ-003 SHALL have parameter TICK_DIV, default 256, clocks per duration tick; legal range is 2 or greater.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port note_valid, input, 1 bit: a note is offered.
REQ-007 SHALL have port note_ready, output, 1 bit: the block can accept a note.
REQ-008 SHALL have port note_period, input, PERIOD_W bits: square-wave half-period in clocks; 0 means a rest.
REQ-009 SHALL have port note_len, input, DUR_W bits: note duration in ticks.
REQ-010 SHALL have port busy, output, 1 bit: high while a note (or gap) is in progress.
REQ-011 SHALL have port audio_out, output, 1 bit: registered square wave, one input line of the downstream mixer.

Function
REQ-012 SHALL use states IDLE, PLAY and GAP; GAP exists only per REQ-029.
REQ-013 SHALL drive note_ready = 1 in IDLE only, combinationally from state, and busy = (state != IDLE).
REQ-014 SHALL accept a note when note_valid and note_ready are both high at a rising edge; note_period and note_len are latched only at accept.
REQ-015 SHALL ignore note_valid outside IDLE; no buffering and no latching occur.
REQ-016 On accept with note_len != 0, SHALL enter PLAY and clear phase counter, tick counter and audio_out to 0.
REQ-017 On accept with note_len == 0, SHALL discard the note and remain in IDLE; audio_out stays 0.
REQ-018 In PLAY with period P != 0, the phase counter SHALL count 0..P-1.
REQ-019 At P-1, audio_out SHALL toggle and the phase counter SHALL return to 0, giving an output period of 2P clocks with a low first half.
REQ-020 P == 1 SHALL toggle audio_out every clock.
REQ-021 In PLAY with P == 0 (rest), audio_out SHALL be held at 0 for the full duration.
REQ-022 The tick counter SHALL count 0..TICK_DIV-1 and wrap; the remaining-length counter SHALL decrement on each wrap.
REQ-023 PLAY SHALL last exactly note_len*TICK_DIV clocks.
REQ-024 On the last PLAY clock, the next state SHALL be GAP (macro defined) or IDLE (macro undefined), and audio_out SHALL be forced to 0 on that edge regardless of phase.
REQ-025 In IDLE, audio_out SHALL be 0 and counters SHALL hold.
REQ-026 The maximum note_len (all ones) SHALL play without wrap; counters are sized so no overflow occurs at any legal parameter value.

Reset
REQ-027 SHALL, when reset is high at a rising edge, set state to IDLE, audio_out to 0, and all counters and latched fields to 0, overriding any concurrent accept or toggle.
REQ-028 SHALL abort a note in progress when reset asserts mid-note; in the cycle after reset deasserts, note_ready = 1, busy = 0 and audio_out = 0.

Configuration
REQ-029 SHALL support macro LOGS_VOICE_GAP_EN: when defined, after PLAY the block enters GAP for exactly TICK_DIV clocks, with audio_out = 0, busy = 1 and note_ready = 0, then goes to IDLE.
REQ-030 When LOGS_VOICE_GAP_EN is undefined, the GAP state and its logic SHALL be absent and PLAY SHALL go directly to IDLE.

Verification (TICK_DIV=4, PERIOD_W=4, DUR_W=4 on bench)
REQ-031 SHALL cover: accept period=3, len=2 at edge E0 -> audio_out over the 8 PLAY cycles = 0,0,0,1,1,1,0,0; cycle 9 is IDLE (GAP off) with note_ready=1.
REQ-032 SHALL cover: period=1, len=1 -> audio_out = 0,1,0,1 then 0; busy high for exactly 4 cycles (GAP off).
REQ-033 SHALL cover: period=0, len=3 -> audio_out is 0 for 12 cycles, busy high for 12 cycles; and len=0 -> never busy, note_ready stays 1.
REQ-034 SHALL cover: note_valid held high with a second note during PLAY -> second note accepted only on the first IDLE cycle, and its fields are those present at that cycle.
REQ-035 SHALL cover: reset asserted on PLAY cycle 5 of a period=2, len=3 note -> next cycle state IDLE, audio_out=0, busy=0, note_ready=1.
REQ-036 SHALL cover, with LOGS_VOICE_GAP_EN: period=2, len=1 -> 4 PLAY cycles, then 4 GAP cycles with audio_out=0 and busy=1, then note_ready=1.
